// File: rtl/xadc_winner_filter_if.sv
// Sample/result bundle between the XADC readout stage and the winner filter.
// The master side feeds samples and soft clear; the slave side (the filter)
// returns the filtered winner, per-channel averages and frame count.
interface xadc_winner_filter_if #(
  parameter int SAMPLE_WIDTH = 12
);
  logic                    clear;
  logic                    sample_valid;
  logic [SAMPLE_WIDTH-1:0] aux0;
  logic [SAMPLE_WIDTH-1:0] aux1;
  logic [SAMPLE_WIDTH-1:0] aux2;
  logic [SAMPLE_WIDTH-1:0] aux3;
  logic [1:0]              network_output;
  logic                    winner_valid;
  logic                    winner_changed;
  logic [SAMPLE_WIDTH-1:0] avg0;
  logic [SAMPLE_WIDTH-1:0] avg1;
  logic [SAMPLE_WIDTH-1:0] avg2;
  logic [SAMPLE_WIDTH-1:0] avg3;
  logic [15:0]             frame_count;

  modport master (
    output clear, sample_valid, aux0, aux1, aux2, aux3,
    input  network_output, winner_valid, winner_changed,
           avg0, avg1, avg2, avg3, frame_count
  );

  modport slave (
    input  clear, sample_valid, aux0, aux1, aux2, aux3,
    output network_output, winner_valid, winner_changed,
           avg0, avg1, avg2, avg3, frame_count
  );
endinterface

// File: rtl/xadc_winner_filter.sv
// Frame-averaging winner filter for the four XADC aux channels.
// Accumulates 2^AVG_LOG2 samples per channel, publishes truncated averages,
// runs a 4-cycle sequential argmax, then applies threshold + hysteresis to
// produce a stable 2-bit winner with a one-cycle change pulse.
module xadc_winner_filter #(
  parameter int                      SAMPLE_WIDTH = 12,
  parameter int                      AVG_LOG2     = 4,
  parameter logic [SAMPLE_WIDTH-1:0] THRESH       = 12'd256,
  parameter logic [SAMPLE_WIDTH-1:0] HYST         = 12'd64
) (
  input logic                S_AXI_ACLK,
  input logic                S_AXI_ARESETN,
  xadc_winner_filter_if.slave bus
);

  localparam int ACC_W = SAMPLE_WIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;

  logic [SAMPLE_WIDTH-1:0] aux_in  [4];
  logic [ACC_W-1:0]        acc_q   [4];
  logic [ACC_W-1:0]        acc_sum [4];
  logic [SAMPLE_WIDTH-1:0] avg_q   [4];
  logic [CNT_W-1:0]        cnt_q;
  logic                    frame_end;
  logic [15:0]             frame_count_q;

  logic [1:0]              state_q;
  logic [1:0]              idx_q;
  logic [SAMPLE_WIDTH-1:0] best_q;
  logic [1:0]              best_idx_q;
  logic [1:0]              winner_q;
  logic                    winner_valid_q;
  logic                    winner_changed_q;

  logic [SAMPLE_WIDTH-1:0] cur_avg;
  logic [SAMPLE_WIDTH:0]   hyst_sum;
  logic                    meets_thresh;
  logic                    beats_current;

  // Per-channel running sums including the sample currently on the bus.
  always_comb begin
    aux_in[0] = bus.aux0;
    aux_in[1] = bus.aux1;
    aux_in[2] = bus.aux2;
    aux_in[3] = bus.aux3;
    for (int unsigned i = 0; i < 4; i++) begin
      acc_sum[i] = acc_q[i] + ACC_W'(aux_in[i]);
    end
    frame_end = bus.sample_valid && (cnt_q == LAST_SAMPLE);
  end

  // Threshold and hysteresis tests against the scanned best average.
  always_comb begin
    cur_avg       = avg_q[winner_q];
    hyst_sum      = {1'b0, cur_avg} + {1'b0, HYST};
    meets_thresh  = (best_q >= THRESH);
    beats_current = (best_idx_q != winner_q) && ({1'b0, best_q} >= hyst_sum);
  end

  // Accumulators and sample counter; cleared at frame end and on soft clear.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned i = 0; i < 4; i++) acc_q[i] <= '0;
      cnt_q <= '0;
    end else if (bus.clear) begin
      for (int unsigned i = 0; i < 4; i++) acc_q[i] <= '0;
      cnt_q <= '0;
    end else if (bus.sample_valid) begin
      if (frame_end) begin
        for (int unsigned i = 0; i < 4; i++) acc_q[i] <= '0;
        cnt_q <= '0;
      end else begin
        for (int unsigned i = 0; i < 4; i++) acc_q[i] <= acc_sum[i];
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Published averages and completed-frame counter.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned i = 0; i < 4; i++) avg_q[i] <= '0;
      frame_count_q <= '0;
    end else if (bus.clear) begin
      for (int unsigned i = 0; i < 4; i++) avg_q[i] <= '0;
      frame_count_q <= '0;
    end else if (frame_end) begin
      for (int unsigned i = 0; i < 4; i++) begin
        avg_q[i] <= SAMPLE_WIDTH'(acc_sum[i] >> AVG_LOG2);
      end
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  // Scan/decide FSM; a new frame end always restarts the scan at index 0,
  // so a decision pending from the previous frame is simply abandoned.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q          <= ST_ACCUM;
      idx_q            <= '0;
      best_q           <= '0;
      best_idx_q       <= '0;
      winner_q         <= '0;
      winner_valid_q   <= 1'b0;
      winner_changed_q <= 1'b0;
    end else if (bus.clear) begin
      state_q          <= ST_ACCUM;
      idx_q            <= '0;
      best_q           <= '0;
      best_idx_q       <= '0;
      winner_q         <= '0;
      winner_valid_q   <= 1'b0;
      winner_changed_q <= 1'b0;
    end else begin
      winner_changed_q <= 1'b0;
      if (frame_end) begin
        state_q <= ST_SCAN;
        idx_q   <= '0;
      end else begin
        case (state_q)
          ST_SCAN: begin
            if ((idx_q == 2'd0) || (avg_q[idx_q] > best_q)) begin
              best_q     <= avg_q[idx_q];
              best_idx_q <= idx_q;
            end
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) state_q <= ST_DECIDE;
          end
          ST_DECIDE: begin
            state_q <= ST_ACCUM;
            if (!meets_thresh) begin
              winner_valid_q <= 1'b0;
            end else if (!winner_valid_q) begin
              winner_q         <= best_idx_q;
              winner_valid_q   <= 1'b1;
              winner_changed_q <= 1'b1;
            end else if (beats_current) begin
              winner_q         <= best_idx_q;
              winner_changed_q <= 1'b1;
            end
          end
          default: state_q <= ST_ACCUM;
        endcase
      end
    end
  end

  assign bus.network_output = winner_q;
  assign bus.winner_valid   = winner_valid_q;
  assign bus.winner_changed = winner_changed_q;
  assign bus.avg0           = avg_q[0];
  assign bus.avg1           = avg_q[1];
  assign bus.avg2           = avg_q[2];
  assign bus.avg3           = avg_q[3];
  assign bus.frame_count    = frame_count_q;

endmodule

// File: tb/tb_xadc_winner_filter.sv
// Bench for xadc_winner_filter: directed scenarios plus randomized frames,
// checked against an arithmetic frame/decision model.
module tb_xadc_winner_filter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xadc_winner_filter_if #(.SAMPLE_WIDTH(12)) bus ();
  xadc_winner_filter_if #(.SAMPLE_WIDTH(12)) bus2 ();

  xadc_winner_filter #(.SAMPLE_WIDTH(12), .AVG_LOG2(2), .THRESH(12'd256), .HYST(12'd64)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .bus(bus));

  xadc_winner_filter #(.SAMPLE_WIDTH(12), .AVG_LOG2(0), .THRESH(12'd256), .HYST(12'd64)) dut2 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .bus(bus2));

  logic [11:0] av1 [4];
  logic [11:0] av2 [4];
  assign av1[0] = bus.avg0;  assign av1[1] = bus.avg1;
  assign av1[2] = bus.avg2;  assign av1[3] = bus.avg3;
  assign av2[0] = bus2.avg0; assign av2[1] = bus2.avg1;
  assign av2[2] = bus2.avg2; assign av2[3] = bus2.avg3;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one slot per instance.
  int unsigned m_avg [2][4];
  bit          m_valid [2];
  int unsigned m_win [2];
  int unsigned m_fc [2];
  int unsigned fs  [4][4];
  int unsigned fs2 [4][4];

  function automatic void model_reset(input int k);
    for (int c = 0; c < 4; c++) m_avg[k][c] = 0;
    m_valid[k] = 0; m_win[k] = 0; m_fc[k] = 0;
  endfunction

  // Returns 1 when the decision would produce a change pulse.
  function automatic bit model_decide(input int k);
    int unsigned bi = 0;
    for (int i = 1; i < 4; i++) if (m_avg[k][i] > m_avg[k][bi]) bi = i;
    if (m_avg[k][bi] < 256) begin m_valid[k] = 0; return 0; end
    if (!m_valid[k]) begin m_valid[k] = 1; m_win[k] = bi; return 1; end
    if (bi != m_win[k] && m_avg[k][bi] >= m_avg[k][m_win[k]] + 64) begin
      m_win[k] = bi; return 1;
    end
    return 0;
  endfunction

  task automatic strobe(input int unsigned a0, a1, a2, a3);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.aux0 = 12'(a0); bus.aux1 = 12'(a1); bus.aux2 = 12'(a2); bus.aux3 = 12'(a3);
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic set_frame(input int unsigned a0, a1, a2, a3);
    for (int j = 0; j < 4; j++) begin
      fs[j][0] = a0; fs[j][1] = a1; fs[j][2] = a2; fs[j][3] = a3;
    end
  endtask

  // Sends fs as one frame and checks averages, latency and the decision.
  task automatic run_frame(input string name, input int gapmax);
    int unsigned sum [4];
    int unsigned old_win;
    bit old_valid, exp_chg;
    for (int c = 0; c < 4; c++) sum[c] = 0;
    for (int j = 0; j < 4; j++) begin
      strobe(fs[j][0], fs[j][1], fs[j][2], fs[j][3]);
      for (int c = 0; c < 4; c++) sum[c] += fs[j][c];
      if (j < 3) repeat ($urandom_range(0, gapmax)) @(negedge clk);
    end
    for (int c = 0; c < 4; c++) m_avg[0][c] = sum[c] >> 2;
    m_fc[0] = (m_fc[0] + 1) & 32'hFFFF;
    old_win = m_win[0]; old_valid = m_valid[0];
    exp_chg = model_decide(0);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (av1[c] !== 12'(m_avg[0][c])) begin
        n_errors++;
        $display("FAIL %s avg%0d got %0d want %0d", name, c, av1[c], m_avg[0][c]);
      end
    end
    n_checks++;
    if (bus.frame_count !== 16'(m_fc[0])) begin
      n_errors++;
      $display("FAIL %s frame_count got %0d want %0d", name, bus.frame_count, m_fc[0]);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.winner_changed !== 1'b0 || bus.network_output !== 2'(old_win)
        || bus.winner_valid !== old_valid) begin
      n_errors++;
      $display("FAIL %s early_update got chg=%0b out=%0d v=%0b want chg=0 out=%0d v=%0b",
               name, bus.winner_changed, bus.network_output, bus.winner_valid, old_win, old_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.network_output !== 2'(m_win[0]) || bus.winner_valid !== m_valid[0]
        || bus.winner_changed !== exp_chg) begin
      n_errors++;
      $display("FAIL %s decision got out=%0d v=%0b chg=%0b want out=%0d v=%0b chg=%0b",
               name, bus.network_output, bus.winner_valid, bus.winner_changed,
               m_win[0], m_valid[0], exp_chg);
    end
    @(negedge clk);
    n_checks++;
    if (bus.winner_changed !== 1'b0) begin
      n_errors++;
      $display("FAIL %s pulse_width got %0b want 0", name, bus.winner_changed);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.network_output !== 2'd0 || bus.winner_valid !== 1'b0 || bus.winner_changed !== 1'b0
        || bus.frame_count !== 16'd0 || av1[0] !== 12'd0 || av1[1] !== 12'd0
        || av1[2] !== 12'd0 || av1[3] !== 12'd0) begin
      n_errors++;
      $display("FAIL reset_state got out=%0d v=%0b fc=%0d want all 0",
               bus.network_output, bus.winner_valid, bus.frame_count);
    end
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) strobe(1000, 1000, 1000, 1000);
    n_checks++;
    if (bus.frame_count !== 16'd1 || av1[2] !== 12'd1000) begin
      n_errors++;
      $display("FAIL pre_reset_frame got fc=%0d avg2=%0d want 1 1000", bus.frame_count, av1[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.network_output !== 2'd0 || bus.winner_valid !== 1'b0 || bus.winner_changed !== 1'b0
        || bus.frame_count !== 16'd0 || av1[0] !== 12'd0 || av1[1] !== 12'd0
        || av1[2] !== 12'd0 || av1[3] !== 12'd0) begin
      n_errors++;
      $display("FAIL async_reset got out=%0d v=%0b fc=%0d avg2=%0d want all 0",
               bus.network_output, bus.winner_valid, bus.frame_count, av1[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(0); model_reset(1);
    set_frame(0, 0, 0, 0);
    run_frame("zero_frame", 0);
  endtask

  task automatic test_first_winner();
    set_frame(10, 500, 20, 30);
    run_frame("first_winner", 2);
    n_checks++;
    if (bus.network_output !== 2'd1 || bus.winner_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL first_winner_const got out=%0d v=%0b want 1 1", bus.network_output, bus.winner_valid);
    end
  endtask

  task automatic test_hysteresis();
    set_frame(0, 500, 540, 0);
    run_frame("hyst_hold", 1);
    set_frame(0, 500, 600, 0);
    run_frame("hyst_switch", 1);
    n_checks++;
    if (bus.network_output !== 2'd2) begin
      n_errors++;
      $display("FAIL hyst_switch_const got %0d want 2", bus.network_output);
    end
  endtask

  task automatic test_threshold_tie();
    set_frame(50, 50, 50, 50);
    run_frame("below_thresh", 1);
    set_frame(700, 0, 0, 700);
    run_frame("tie_low_index", 1);
    n_checks++;
    if (bus.network_output !== 2'd0 || bus.winner_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL tie_const got out=%0d v=%0b want 0 1", bus.network_output, bus.winner_valid);
    end
  endtask

  task automatic test_arith();
    set_frame(2, 0, 0, 0);
    fs[0][0] = 1;
    run_frame("truncation", 0);
    n_checks++;
    if (av1[0] !== 12'd1) begin
      n_errors++;
      $display("FAIL truncation_const got %0d want 1", av1[0]);
    end
    set_frame(4095, 4095, 4095, 4095);
    run_frame("full_scale", 0);
  endtask

  task automatic test_clear_overlap();
    strobe(4000, 4000, 4000, 4000);
    strobe(4000, 4000, 4000, 4000);
    @(negedge clk);
    bus.sample_valid = 1'b1; bus.clear = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0; bus.clear = 1'b0;
    model_reset(0);
    n_checks++;
    if (bus.frame_count !== 16'd0 || bus.winner_valid !== 1'b0 || bus.network_output !== 2'd0
        || av1[0] !== 12'd0) begin
      n_errors++;
      $display("FAIL clear got fc=%0d v=%0b out=%0d avg0=%0d want 0",
               bus.frame_count, bus.winner_valid, bus.network_output, av1[0]);
    end
    for (int j = 0; j < 4; j++) for (int c = 0; c < 4; c++) fs[j][c] = $urandom_range(0, 900);
    run_frame("after_clear", 1);
  endtask

  task automatic test_back_to_back();
    int unsigned old_win;
    bit old_valid, exp_chg;
    int unsigned sum [4];
    for (int j = 0; j < 4; j++) for (int c = 0; c < 4; c++) begin
      fs[j][c]  = (c == 3) ? 3000 : $urandom_range(0, 200);
      fs2[j][c] = (c == 1) ? $urandom_range(1000, 4095) : $urandom_range(0, 900);
    end
    for (int j = 0; j < 3; j++) strobe(fs[j][0], fs[j][1], fs[j][2], fs[j][3]);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j == 0) begin
        bus.aux0 = 12'(fs[3][0]); bus.aux1 = 12'(fs[3][1]);
        bus.aux2 = 12'(fs[3][2]); bus.aux3 = 12'(fs[3][3]);
      end else begin
        bus.aux0 = 12'(fs2[j-1][0]); bus.aux1 = 12'(fs2[j-1][1]);
        bus.aux2 = 12'(fs2[j-1][2]); bus.aux3 = 12'(fs2[j-1][3]);
      end
      @(negedge clk);
    end
    bus.sample_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sum[c] = 0;
      for (int j = 0; j < 4; j++) sum[c] += fs2[j][c];
      m_avg[0][c] = sum[c] >> 2;
    end
    m_fc[0] = (m_fc[0] + 2) & 32'hFFFF;
    old_win = m_win[0]; old_valid = m_valid[0];
    exp_chg = model_decide(0);
    n_checks++;
    if (bus.frame_count !== 16'(m_fc[0]) || av1[1] !== 12'(m_avg[0][1])) begin
      n_errors++;
      $display("FAIL b2b_avg got fc=%0d avg1=%0d want %0d %0d",
               bus.frame_count, av1[1], m_fc[0], m_avg[0][1]);
    end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.winner_changed !== 1'b0 || bus.network_output !== 2'(old_win)
          || bus.winner_valid !== old_valid) begin
        n_errors++;
        $display("FAIL b2b_discard t+%0d got chg=%0b out=%0d v=%0b want 0 %0d %0b",
                 k, bus.winner_changed, bus.network_output, bus.winner_valid, old_win, old_valid);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.network_output !== 2'(m_win[0]) || bus.winner_valid !== m_valid[0]
        || bus.winner_changed !== exp_chg) begin
      n_errors++;
      $display("FAIL b2b_decision got out=%0d v=%0b chg=%0b want %0d %0b %0b",
               bus.network_output, bus.winner_valid, bus.winner_changed,
               m_win[0], m_valid[0], exp_chg);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      int unsigned fav;
      fav = $urandom_range(0, 3);
      for (int j = 0; j < 4; j++) for (int c = 0; c < 4; c++)
        fs[j][c] = $urandom_range(0, 800) + ((c == fav) ? $urandom_range(0, 900) : 0);
      run_frame("random", 3);
    end
  endtask

  task automatic test_restart_gap3();
    bit exp_chg;
    @(negedge clk);
    bus2.sample_valid = 1'b1;
    bus2.aux0 = 12'd0; bus2.aux1 = 12'd0; bus2.aux2 = 12'd900; bus2.aux3 = 12'd0;
    @(negedge clk);
    bus2.sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus2.sample_valid = 1'b1;
    bus2.aux0 = 12'd300; bus2.aux1 = 12'd0; bus2.aux2 = 12'd10; bus2.aux3 = 12'd0;
    @(negedge clk);
    bus2.sample_valid = 1'b0;
    m_avg[1][0] = 300; m_avg[1][1] = 0; m_avg[1][2] = 10; m_avg[1][3] = 0;
    m_fc[1] = (m_fc[1] + 2) & 32'hFFFF;
    n_checks++;
    if (bus2.frame_count !== 16'(m_fc[1]) || av2[0] !== 12'd300 || av2[2] !== 12'd10) begin
      n_errors++;
      $display("FAIL gap3_avg got fc=%0d avg0=%0d avg2=%0d want %0d 300 10",
               bus2.frame_count, av2[0], av2[2], m_fc[1]);
    end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus2.winner_changed !== 1'b0 || bus2.winner_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL gap3_discard t+%0d got chg=%0b v=%0b want 0 0",
                 k, bus2.winner_changed, bus2.winner_valid);
      end
    end
    exp_chg = model_decide(1);
    @(negedge clk);
    n_checks++;
    if (bus2.network_output !== 2'(m_win[1]) || bus2.winner_valid !== m_valid[1]
        || bus2.winner_changed !== exp_chg) begin
      n_errors++;
      $display("FAIL gap3_decision got out=%0d v=%0b chg=%0b want %0d %0b %0b",
               bus2.network_output, bus2.winner_valid, bus2.winner_changed,
               m_win[1], m_valid[1], exp_chg);
    end
  endtask

  task automatic test_frame_wrap();
    bit exp_chg;
    @(negedge clk);
    bus2.clear = 1'b1;
    @(negedge clk);
    bus2.clear = 1'b0;
    model_reset(1);
    bus2.sample_valid = 1'b1;
    bus2.aux0 = 12'd100; bus2.aux1 = 12'd2000; bus2.aux2 = 12'd5; bus2.aux3 = 12'd7;
    repeat (65535) @(negedge clk);
    m_fc[1] = 65535;
    n_checks++;
    if (bus2.frame_count !== 16'(m_fc[1])) begin
      n_errors++;
      $display("FAIL wrap_pre got %0d want %0d", bus2.frame_count, m_fc[1]);
    end
    @(negedge clk);
    bus2.sample_valid = 1'b0;
    m_fc[1] = (m_fc[1] + 1) & 32'hFFFF;
    m_avg[1][0] = 100; m_avg[1][1] = 2000; m_avg[1][2] = 5; m_avg[1][3] = 7;
    n_checks++;
    if (bus2.frame_count !== 16'(m_fc[1]) || av2[1] !== 12'd2000 || av2[3] !== 12'd7) begin
      n_errors++;
      $display("FAIL wrap got fc=%0d avg1=%0d avg3=%0d want %0d 2000 7",
               bus2.frame_count, av2[1], av2[3], m_fc[1]);
    end
    exp_chg = model_decide(1);
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus2.network_output !== 2'(m_win[1]) || bus2.winner_valid !== m_valid[1]
        || bus2.winner_changed !== exp_chg) begin
      n_errors++;
      $display("FAIL wrap_decision got out=%0d v=%0b chg=%0b want %0d %0b %0b",
               bus2.network_output, bus2.winner_valid, bus2.winner_changed,
               m_win[1], m_valid[1], exp_chg);
    end
  endtask

  initial begin
    bus.clear = 1'b0;  bus.sample_valid = 1'b0;
    bus.aux0 = '0; bus.aux1 = '0; bus.aux2 = '0; bus.aux3 = '0;
    bus2.clear = 1'b0; bus2.sample_valid = 1'b0;
    bus2.aux0 = '0; bus2.aux1 = '0; bus2.aux2 = '0; bus2.aux3 = '0;
    test_reset();
    test_first_winner();
    test_hysteresis();
    test_threshold_tie();
    test_arith();
    test_clear_overlap();
    test_back_to_back();
    test_random();
    test_restart_gap3();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
